// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state encoding and parameter defaults for regfile_checker
package checker_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_REGS    = 32;
  localparam int DEF_CYC_W       = 20;
  localparam int DEF_TRACE_DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_checker_if.sv
// rtl/regfile_checker_if.sv - write-trace stream and mismatch report bundle
interface regfile_checker_if
  import checker_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(DEF_NUM_REGS),
  parameter int CYC_W  = DEF_CYC_W
);

  logic              trace_valid;
  logic              trace_ready;
  logic [CYC_W-1:0]  trace_cycle;
  logic [ADDR_W-1:0] trace_reg;
  logic [DATA_W-1:0] trace_data;
  logic              fail_valid;
  logic [ADDR_W-1:0] fail_reg;
  logic [DATA_W-1:0] fail_act;

  modport master (
    output trace_valid, trace_cycle, trace_reg, trace_data,
    output fail_valid, fail_reg, fail_act,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_cycle, trace_reg, trace_data,
    input  fail_valid, fail_reg, fail_act,
    output trace_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO holding write-trace entries
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_checker.sv
// rtl/regfile_checker.sv - traces regfile writes during a run, then scans the regfile against a ROM
module regfile_checker
  import checker_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int CYC_W       = DEF_CYC_W,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              rwe,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rdata,
  output logic              test_mode,
  output logic [ADDR_W-1:0] test_reg,
  input  logic [DATA_W-1:0] regA,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              trace_overflow,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  regfile_checker_if.master trace
);

  localparam int ENTRY_W = CYC_W + ADDR_W + DATA_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] ERR_MAX  = '1;

  state_t            state, state_n;
  logic [CYC_W-1:0]  cnt, num_q;
  logic [ADDR_W:0]   idx, err_q, err_n;
  logic [DATA_W-1:0] rega_q;
  logic [ADDR_W-1:0] k_q;
  logic              done_q, pass_q, ovf_q;
  logic              start_ok, scan_issue, compare, mismatch;
  logic              push, pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] pop_data;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = (num_cycles == '0) ? S_SCAN : S_RUN;
        end
      end
      S_RUN:   if (cnt == num_q - CYC_W'(1)) state_n = S_SCAN;
      S_SCAN:  if (idx == LAST_IDX) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Scan cycle k issues address k; cycle k+1 compares against the ROM word it returned.
  assign test_mode  = (state == S_SCAN);
  assign scan_issue = test_mode && (idx != LAST_IDX);
  assign test_reg   = scan_issue ? idx[ADDR_W-1:0] : '0;
  assign exp_addr   = test_reg;
  assign compare    = test_mode && (idx != '0);
  assign mismatch   = compare && (rega_q != exp_data);

  always_comb begin
    err_n = err_q;
    if (mismatch && (err_q != ERR_MAX)) err_n = err_q + (ADDR_W+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      num_q  <= '0;
      idx    <= '0;
      rega_q <= '0;
      k_q    <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start_ok) begin
      cnt    <= '0;
      num_q  <= num_cycles;
      idx    <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state == S_RUN) cnt <= cnt + CYC_W'(1);
      if (test_mode) begin
        idx    <= idx + (ADDR_W+1)'(1);
        rega_q <= regA;
        k_q    <= test_reg;
        err_q  <= err_n;
      end
      if (test_mode && (idx == LAST_IDX)) begin
        done_q <= 1'b1;
        pass_q <= (err_n == '0);
      end
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign push = (state == S_RUN) && rwe && (rd != '0);
  assign pop  = trace.trace_valid && trace.trace_ready;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (start_ok),
    .push      (push),
    .push_data ({cnt, rd, rdata}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace.trace_valid = !fifo_empty;
  assign {trace.trace_cycle, trace.trace_reg, trace.trace_data} = pop_data;
  assign trace.fail_valid  = mismatch;
  assign trace.fail_reg    = k_q;
  assign trace.fail_act    = rega_q;

  assign trace_overflow = ovf_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;

endmodule
